bucket_sch_arb: RTL and testbench

BUCKET_SCH_ARB -- requirements
Module: bucket_sch_arb

---
 rtl/bucket_sch_arb_pkg.sv | 18 +
 rtl/bucket_rr_sel.sv | 33 +++
 rtl/bucket_sch_arb.sv | 136 +++++++++++++
 tb/tb_bucket_sch_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bucket_sch_arb_pkg.sv
// Shared definitions for the bucket scheduler arbiter: FSM state encoding,
// default frame-length width and the round-robin pointer width helper.
package bucket_sch_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARB    = 2'd1,
      ST_GRANT  = 2'd2,
      ST_SETTLE = 2'd3
   } sch_state_t;

   localparam int DEF_LEN_WIDTH = 11;

   function automatic int rr_ptr_width(input int port_num);
      return (port_num > 1) ? $clog2(port_num) : 1;
   endfunction

endpackage

// File: rtl/bucket_rr_sel.sv
// Combinational round-robin search: the first requesting port at or above ptr,
// wrapping from PORT_NUM-1 back to 0, returned one-hot.
module bucket_rr_sel
   import bucket_sch_arb_pkg::*;
#(
   parameter int PORT_NUM = 4,
   parameter int PTR_W    = rr_ptr_width(PORT_NUM)
) (
   input  logic [PORT_NUM-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [PORT_NUM-1:0] winner
);

   logic             found_s;
   logic [PTR_W-1:0] idx_s;

   // Scan ports in priority order starting from ptr; the first hit wins.
   always_comb begin
      winner  = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         idx_s = PTR_W'((int'(ptr) + i) % PORT_NUM);
         if (!found_s && req[idx_s]) begin
            winner[idx_s] = 1'b1;
            found_s       = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/bucket_sch_arb.sv
// Token-bucket scheduler arbiter: round-robin grant of one frame at a time,
// charging its length into the bucket. BUCKET_SCH_STRICT_PRI_EN makes port 0 strict-priority.
module bucket_sch_arb
   import bucket_sch_arb_pkg::*;
#(
   parameter int PORT_NUM   = 4,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int SETTLE_CYC = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PORT_NUM-1:0]           port_req,
   input  logic [PORT_NUM*LEN_WIDTH-1:0] port_len,
   output logic [PORT_NUM-1:0]           port_gnt,
   input  logic                          bucket_af,
   input  logic                          bucket_full_time_over,
   output logic                          bucket_inc_wr,
   output logic [LEN_WIDTH-1:0]          bucket_inc_wdata,
   output logic                          sch_busy,
   output logic                          sch_err,
   output logic                          sch_hang
);

   localparam int PTR_W = rr_ptr_width(PORT_NUM);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORT_NUM - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   sch_state_t           state_r, state_nx_s;
   logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_nx_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
   logic [PORT_NUM-1:0]  winner_r, winner_nx_s;
   logic [PORT_NUM-1:0]  sel_req_s, rr_win_s, arb_win_s;
   logic [LEN_WIDTH-1:0] win_len_s;
   logic [PTR_W-1:0]     win_idx_s;
   logic                 grant_s;
   logic                 hang_r;

`ifdef BUCKET_SCH_STRICT_PRI_EN
   localparam logic [PORT_NUM-1:0] PORT0_MASK = PORT_NUM'(1);
   // Port 0 pre-empts the rotation; the others rotate among themselves.
   assign sel_req_s = port_req & ~PORT0_MASK;
   assign arb_win_s = port_req[0] ? PORT0_MASK : rr_win_s;
`else
   assign sel_req_s = port_req;
   assign arb_win_s = rr_win_s;
`endif

   bucket_rr_sel #(
      .PORT_NUM (PORT_NUM),
      .PTR_W    (PTR_W)
   ) u_rr_sel (
      .req    (sel_req_s),
      .ptr    (rr_ptr_r),
      .winner (rr_win_s)
   );

   // Decode the registered one-hot winner into its index and frame length.
   always_comb begin
      win_len_s = '0;
      win_idx_s = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         win_len_s = win_len_s | (winner_r[i] ? port_len[i*LEN_WIDTH +: LEN_WIDTH] : '0);
         win_idx_s = win_idx_s | (winner_r[i] ? PTR_W'(i) : '0);
      end
   end

   // Reset gates the grant so a reset landing in GRANT never leaks a strobe.
   assign grant_s = (state_r == ST_GRANT) && ((winner_r & port_req) != '0) && !reset;

   // Next-state, winner capture, pointer advance and settle counting.
   always_comb begin
      state_nx_s  = state_r;
      rr_ptr_nx_s = rr_ptr_r;
      cnt_nx_s    = cnt_r;
      winner_nx_s = winner_r;
      case (state_r)
         ST_IDLE: begin
            if ((port_req != '0) && !bucket_af) begin
               state_nx_s = ST_ARB;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ARB: begin
            winner_nx_s = arb_win_s;
            state_nx_s  = ST_GRANT;
         end
         ST_GRANT: begin
            if (grant_s) begin
               rr_ptr_nx_s = (win_idx_s == LAST_PORT) ? '0 : win_idx_s + 1'b1;
               cnt_nx_s    = '0;
               state_nx_s  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_IDLE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r >= CNT_LAST) begin
               state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r + 1'b1;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         rr_ptr_r <= '0;
         cnt_r    <= '0;
         winner_r <= '0;
         hang_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         rr_ptr_r <= rr_ptr_nx_s;
         cnt_r    <= cnt_nx_s;
         winner_r <= winner_nx_s;
         hang_r   <= bucket_full_time_over;
      end
   end

   // A zero-length winner is granted but must not charge the bucket.
   assign port_gnt         = grant_s ? winner_r : '0;
   assign bucket_inc_wr    = grant_s && (win_len_s != '0);
   assign bucket_inc_wdata = bucket_inc_wr ? win_len_s : '0;
   assign sch_err          = grant_s && (win_len_s == '0);
   assign sch_busy         = (state_r != ST_IDLE);
   assign sch_hang         = hang_r;

endmodule

// File: tb/tb_bucket_sch_arb.sv
// Bench for bucket_sch_arb: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a timestamp-based reference model.
module tb_bucket_sch_arb;

   localparam int N      = 4;
   localparam int LW     = 11;
   localparam int SETTLE = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    port_req;
   logic [N*LW-1:0] port_len;
   logic [N-1:0]    port_gnt;
   logic            bucket_af;
   logic            bucket_full_time_over;
   logic            bucket_inc_wr;
   logic [LW-1:0]   bucket_inc_wdata;
   logic            sch_busy;
   logic            sch_err;
   logic            sch_hang;

   always #5 clk = ~clk;

   bucket_sch_arb #(
      .PORT_NUM   (N),
      .LEN_WIDTH  (LW),
      .SETTLE_CYC (SETTLE)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .port_req              (port_req),
      .port_len              (port_len),
      .port_gnt              (port_gnt),
      .bucket_af             (bucket_af),
      .bucket_full_time_over (bucket_full_time_over),
      .bucket_inc_wr         (bucket_inc_wr),
      .bucket_inc_wdata      (bucket_inc_wdata),
      .sch_busy              (sch_busy),
      .sch_err               (sch_err),
      .sch_hang              (sch_hang)
   );

   // stimulus intent for the next cycle
   logic          rst_v;
   logic [N-1:0]  req_v;
   logic [LW-1:0] len_v [N];
   logic          af_v;
   logic          fto_v;
   bit            hold_all;

   // reference model: timestamps instead of states
   int cyc, free_at, pend_at, win, ptr;
   bit prev_hang, model_valid;

   int n_chk, n_pass;
   int g_cyc [N];
   int err_cnt;
   int gq [$];
   int s;
   int exp_order [5];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
   endtask

   function automatic int pick(input logic [N-1:0] r_in, input int p);
      logic [N-1:0] r;
      r = r_in;
`ifdef BUCKET_SCH_STRICT_PRI_EN
      if (r[0]) return 0;
      r[0] = 1'b0;
`endif
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      logic [N-1:0]  eg;
      logic          ew, ee, eb, eh;
      logic [LW-1:0] ed;
      @(posedge clk);
      #1;
      reset                 = rst_v;
      port_req              = req_v;
      for (int i = 0; i < N; i++) port_len[i*LW +: LW] = len_v[i];
      bucket_af             = af_v;
      bucket_full_time_over = fto_v;
      @(negedge clk);
      eb = !(cyc >= free_at && pend_at < 0);
      eg = '0; ew = 1'b0; ed = '0; ee = 1'b0; eh = prev_hang;
      if (rst_v) begin
         free_at = cyc + 1; pend_at = -1; ptr = 0;
      end else if (pend_at >= 0 && cyc == pend_at) begin
         win = pick(req_v, ptr);
      end else if (pend_at >= 0 && cyc == pend_at + 1) begin
         if (win >= 0 && req_v[win]) begin
            eg[win] = 1'b1;
            ew = (len_v[win] != 0);
            ed = ew ? len_v[win] : '0;
            ee = (len_v[win] == 0);
            ptr = (win + 1) % N;
            free_at = cyc + 1 + SETTLE;
         end else begin
            free_at = cyc + 1;
         end
         pend_at = -1;
      end else if (!eb && req_v != 0 && !af_v) begin
         pend_at = cyc + 1;
      end
      if (model_valid) begin
         chk("gnt",   32'(port_gnt), 32'(eg));
         chk("inc_wr", 32'(bucket_inc_wr), 32'(ew));
         chk("wdata", 32'(bucket_inc_wdata), 32'(ed));
         chk("err",   32'(sch_err), 32'(ee));
         chk("busy",  32'(sch_busy), 32'(eb));
         chk("hang",  32'(sch_hang), 32'(eh));
      end
      if (rst_v) model_valid = 1'b1;
      prev_hang = rst_v ? 1'b0 : fto_v;
      for (int i = 0; i < N; i++) begin
         if (port_gnt[i] === 1'b1) begin
            g_cyc[i] = cyc;
            gq.push_back(i);
         end
      end
      if (sch_err === 1'b1) err_cnt++;
      for (int i = 0; i < N; i++) begin
         if (eg[i] && !hold_all) req_v[i] = 1'b0;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      for (int i = 0; i < N; i++) g_cyc[i] = -100;
      gq.delete();
      err_cnt = 0;
   endtask

   task automatic do_reset();
      rst_v = 1'b1; run(2); rst_v = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; free_at = 0; pend_at = -1; win = -1; ptr = 0;
      prev_hang = 1'b0; model_valid = 1'b0; hold_all = 1'b0;
      rst_v = 1'b1; req_v = '0; af_v = 1'b0; fto_v = 1'b0;
      for (int i = 0; i < N; i++) len_v[i] = '0;
      reset = 1'b1; port_req = '0; port_len = '0; bucket_af = 1'b0; bucket_full_time_over = 1'b0;
      clear_log();
      do_reset();

      // two ports, back-to-back grants
      clear_log();
      req_v = 4'b0101; len_v[0] = 11'd64; len_v[2] = 11'd100;
      s = cyc;
      run(14);
      chk("lat_p0", 32'(g_cyc[0] - s), 32'd2);
      chk("gap_p0_p2", 32'(g_cyc[2] - g_cyc[0]), 32'd5);

      // almost-full blocks arbitration until it drops
      clear_log();
      af_v = 1'b1; req_v[1] = 1'b1; len_v[1] = 11'd200;
      run(6);
      chk("af_block", 32'(g_cyc[1]), 32'hFFFF_FF9C);
      af_v = 1'b0; s = cyc;
      run(8);
      chk("af_release_lat", 32'(g_cyc[1] - s), 32'd2);

      // zero-length frame
      clear_log();
      req_v[3] = 1'b1; len_v[3] = 11'd0;
      run(8);
      chk("zero_len_gnt", 32'(g_cyc[3] >= 0), 32'd1);
      chk("err_once", 32'(err_cnt), 32'd1);

      // request withdrawn during ARB: no grant, pointer untouched
      clear_log();
      req_v[1] = 1'b1; len_v[1] = 11'd33;
      step();
      req_v[1] = 1'b0;
      run(5);
      chk("drop_no_gnt", 32'(gq.size()), 32'd0);
      req_v = 4'b1010; len_v[1] = 11'd5; len_v[3] = 11'd7;
      run(14);
      chk("ptr_kept", 32'((gq.size() > 0) ? gq[0] : -1), 32'd1);

      // all ports requesting continuously
      do_reset();
      clear_log();
      hold_all = 1'b1;
      req_v = 4'b1111; len_v[0] = 11'd10; len_v[1] = 11'd20; len_v[2] = 11'd30; len_v[3] = 11'd40;
      run(30);
      hold_all = 1'b0; req_v = '0;
      run(6);
`ifdef BUCKET_SCH_STRICT_PRI_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      for (int k = 0; k < 5; k++) chk($sformatf("order%0d", k), 32'((gq.size() > k) ? gq[k] : -1), 32'(exp_order[k]));

      // reset landing in SETTLE
      clear_log();
      req_v[2] = 1'b1; len_v[2] = 11'd77;
      run(4);
      rst_v = 1'b1; step(); rst_v = 1'b0;
      step();
      chk("rst_busy", 32'(sch_busy), 32'd0);
      chk("rst_gnt", 32'(port_gnt), 32'd0);
      clear_log();
      req_v = 4'b1010; len_v[1] = 11'd9; len_v[3] = 11'd11;
      run(14);
      chk("rst_ptr_zero", 32'((gq.size() > 0) ? gq[0] : -1), 32'd1);

      // randomized traffic
      for (int t = 0; t < 3000; t++) begin
         rst_v = ($urandom_range(0, 299) == 0);
         af_v  = ($urandom_range(0, 3) == 0);
         fto_v = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            if (!req_v[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_v[i] = 1'b1;
                  len_v[i] = ($urandom_range(0, 7) == 0) ? 11'd0 : LW'($urandom_range(1, 2047));
               end
            end else if ($urandom_range(0, 59) == 0) begin
               req_v[i] = 1'b0;
            end
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
